// File: rtl/fread_arbiter.sv
// Round-robin arbiter sharing one file-reader request port and its
// response buffer between requester A (CSR path) and B (prefetch).
module fread_arbiter #(
    parameter int unsigned TIMEOUT = 1048576,
    parameter int unsigned TW      = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a_file_id,
    input  logic [31:0] a_offset,
    input  logic [10:0] a_len,
    input  logic        a_valid,
    output logic        a_ready,
    output logic        a_done,
    output logic        a_err,
    input  logic        a_release,
    input  logic [8:0]  a_raddr,
    input  logic [31:0] b_file_id,
    input  logic [31:0] b_offset,
    input  logic [10:0] b_len,
    input  logic        b_valid,
    output logic        b_ready,
    output logic        b_done,
    output logic        b_err,
    input  logic        b_release,
    input  logic [8:0]  b_raddr,
    output logic [31:0] m_file_id,
    output logic [31:0] m_offset,
    output logic [10:0] m_len,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        m_done,
    output logic [8:0]  m_raddr,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    state_e      state_q, state_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_file_id_q, m_file_id_d;
    logic [31:0] m_offset_q, m_offset_d;
    logic [10:0] m_len_q, m_len_d;
    logic [1:0]  owner_q, owner_d;
    logic        a_done_q, a_done_d;
    logic        b_done_q, b_done_d;
    logic        a_err_q, a_err_d;
    logic        b_err_q, b_err_d;
    logic        rr_q, rr_d;
    logic        done_q, done_d;
    logic [TW-1:0] timer_q, timer_d;

    logic idle;
    logic done_rise;
    logic expired;
    logic rel;

    // rr_q == 1 means B was served last, so A wins the next tie.
    assign idle    = (state_q == IDLE);
    assign a_ready = idle & a_valid & (~b_valid | rr_q);
    assign b_ready = idle & b_valid & (~a_valid | ~rr_q);

    assign done_rise = m_done & ~done_q;
    assign expired   = (timer_q == TW'(TIMEOUT - 1));
    assign rel       = (owner_q[0] & a_release) | (owner_q[1] & b_release);

    always_comb begin
        state_d     = state_q;
        m_valid_d   = m_valid_q;
        m_file_id_d = m_file_id_q;
        m_offset_d  = m_offset_q;
        m_len_d     = m_len_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        timer_d     = timer_q;
        done_d      = m_done;
        a_done_d    = 1'b0;
        b_done_d    = 1'b0;
        a_err_d     = 1'b0;
        b_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                unique case (1'b1)
                    a_ready: begin
                        m_file_id_d = a_file_id;
                        m_offset_d  = a_offset;
                        m_len_d     = a_len;
                        owner_d     = 2'b01;
                        m_valid_d   = 1'b1;
                        state_d     = ISSUE;
                    end
                    b_ready: begin
                        m_file_id_d = b_file_id;
                        m_offset_d  = b_offset;
                        m_len_d     = b_len;
                        owner_d     = 2'b10;
                        m_valid_d   = 1'b1;
                        state_d     = ISSUE;
                    end
                    default: ;
                endcase
            end
            ISSUE: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    timer_d   = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // A completion in the expiry cycle still counts as success.
                if (done_rise || expired) begin
                    a_done_d = owner_q[0];
                    b_done_d = owner_q[1];
                    a_err_d  = owner_q[0] & ~done_rise;
                    b_err_d  = owner_q[1] & ~done_rise;
                    state_d  = HOLD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                if (rel) begin
                    rr_d    = owner_q[1];
                    owner_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            m_file_id_q <= '0;
            m_offset_q  <= '0;
            m_len_q     <= '0;
            owner_q     <= 2'b00;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            rr_q        <= 1'b1;
            done_q      <= 1'b1;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            m_file_id_q <= m_file_id_d;
            m_offset_q  <= m_offset_d;
            m_len_q     <= m_len_d;
            owner_q     <= owner_d;
            a_done_q    <= a_done_d;
            b_done_q    <= b_done_d;
            a_err_q     <= a_err_d;
            b_err_q     <= b_err_d;
            rr_q        <= rr_d;
            done_q      <= done_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        m_raddr = 9'h000;
        if (owner_q[0]) begin
            m_raddr = a_raddr;
        end else if (owner_q[1]) begin
            m_raddr = b_raddr;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_file_id = m_file_id_q;
    assign m_offset  = m_offset_q;
    assign m_len     = m_len_q;
    assign owner     = owner_q;
    assign a_done    = a_done_q;
    assign b_done    = b_done_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;

endmodule

// File: tb/tb_fread_arbiter.sv
// Directed bench for fread_arbiter: ready tables, raddr mux table and
// hand-written transaction, timeout, tie and mid-issue reset sequences.
module tb_fread_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_file_id, a_offset, b_file_id, b_offset;
    logic [10:0] a_len, b_len;
    logic        a_valid, a_ready, a_done, a_err, a_release;
    logic        b_valid, b_ready, b_done, b_err, b_release;
    logic [8:0]  a_raddr, b_raddr, m_raddr;
    logic [31:0] m_file_id, m_offset;
    logic [10:0] m_len;
    logic        m_valid, m_ready, m_done;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;
    int cnt;

    typedef struct {
        logic av;
        logic bv;
        logic exp_ar;
        logic exp_br;
    } rdy_vec_t;

    typedef struct {
        logic [8:0] ar;
        logic [8:0] br;
        logic [8:0] exp;
    } rd_vec_t;

    rdy_vec_t rv0[4];
    rdy_vec_t rv1[4];
    rd_vec_t  rdv[3];

    fread_arbiter #(.TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_file_id(a_file_id), .a_offset(a_offset), .a_len(a_len),
        .a_valid(a_valid), .a_ready(a_ready), .a_done(a_done),
        .a_err(a_err), .a_release(a_release), .a_raddr(a_raddr),
        .b_file_id(b_file_id), .b_offset(b_offset), .b_len(b_len),
        .b_valid(b_valid), .b_ready(b_ready), .b_done(b_done),
        .b_err(b_err), .b_release(b_release), .b_raddr(b_raddr),
        .m_file_id(m_file_id), .m_offset(m_offset), .m_len(m_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_done(m_done),
        .m_raddr(m_raddr), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Entered at a negedge with m_valid high; returns at the first
    // WAIT-cycle negedge with m_done dropped.
    task automatic handshake(input int dly);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("m_valid_hold", m_valid, 1'b1);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        m_done  = 1'b0;
        check("m_valid_drop", m_valid, 1'b0);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (a_done || b_done) break;
        end
    endtask

    initial begin
        rv0[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        rv0[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rv0[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rv0[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        rv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        rv1[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rv1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        rdv[0] = '{9'h0AB, 9'h000, 9'h0AB};
        rdv[1] = '{9'h0AB, 9'h1FF, 9'h0AB};
        rdv[2] = '{9'h155, 9'h0CD, 9'h155};

        rst_n = 1'b0;
        a_file_id = '0; a_offset = '0; a_len = '0; a_valid = 1'b0;
        b_file_id = '0; b_offset = '0; b_len = '0; b_valid = 1'b0;
        a_release = 1'b0; b_release = 1'b0;
        a_raddr = '0; b_raddr = '0;
        m_ready = 1'b0; m_done = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_owner", owner, 2'b00);
        check("rst_done", {a_done, b_done, a_err, b_err}, 4'b0);
        check("rst_fields", {m_file_id, m_offset, m_len}, 75'b0);
        check("rst_raddr", m_raddr, 9'h000);
        rst_n = 1'b1;

        // Ready table with A holding tie priority.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_valid = rv0[i].av;
            b_valid = rv0[i].bv;
            #1;
            check($sformatf("rdy0_%0d_a", i), a_ready, rv0[i].exp_ar);
            check($sformatf("rdy0_%0d_b", i), b_ready, rv0[i].exp_br);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end

        // Single A transaction.
        @(negedge clk);
        a_file_id = 32'h12; a_offset = 32'h400; a_len = 11'h1FF;
        a_valid = 1'b1;
        #1 check("s1_a_ready", a_ready, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        check("s1_m_valid", m_valid, 1'b1);
        check("s1_file", m_file_id, 32'h12);
        check("s1_off", m_offset, 32'h400);
        check("s1_len", m_len, 11'h1FF);
        check("s1_owner", owner, 2'b01);
        handshake(2);
        repeat (9) @(negedge clk);
        m_done = 1'b1;
        wait_done(20, cnt);
        check("s1_done_lat", cnt, 1);
        check("s1_a_done", {a_done, a_err, b_done, b_err}, 4'b1000);
        check("s1_owner_hold", owner, 2'b01);
        @(negedge clk);
        check("s1_pulse", {a_done, a_err}, 2'b00);

        b_release = 1'b1;
        @(negedge clk);
        b_release = 1'b0;
        check("s1_brel_ign", owner, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_raddr = rdv[i].ar;
            b_raddr = rdv[i].br;
            #1 check($sformatf("raddr_%0d", i), m_raddr, rdv[i].exp);
        end
        @(negedge clk);
        a_release = 1'b1;
        @(negedge clk);
        a_release = 1'b0;
        check("s1_release", owner, 2'b00);
        check("s1_idle_raddr", m_raddr, 9'h000);

        // Ready table after A was served: B wins the tie.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_valid = rv1[i].av;
            b_valid = rv1[i].bv;
            #1;
            check($sformatf("rdy1_%0d_a", i), a_ready, rv1[i].exp_ar);
            check($sformatf("rdy1_%0d_b", i), b_ready, rv1[i].exp_br);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end

        // Tie after reset, then alternation.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_file_id = 32'h21; a_offset = 32'h800; a_len = 11'h010;
        b_file_id = 32'h33; b_offset = 32'hC00; b_len = 11'h020;
        a_valid = 1'b1; b_valid = 1'b1;
        #1 check("tie1", {a_ready, b_ready}, 2'b10);
        @(negedge clk);
        a_valid = 1'b0;
        check("tie1_owner", owner, 2'b01);
        check("tie1_file", m_file_id, 32'h21);
        check("tie1_b_stall", b_ready, 1'b0);
        handshake(0);
        repeat (2) @(negedge clk);
        m_done = 1'b1;
        wait_done(20, cnt);
        check("tie1_lat", cnt, 1);
        check("tie1_done", {a_done, a_err, b_done}, 3'b100);
        @(negedge clk);
        check("tie1_hold_b", b_ready, 1'b0);
        a_release = 1'b1;
        @(negedge clk);
        a_release = 1'b0;
        check("tie1_rel", owner, 2'b00);
        check("tie2_b_ready", b_ready, 1'b1);
        @(negedge clk);
        b_valid = 1'b0;
        check("tie2_owner", owner, 2'b10);
        check("tie2_file", m_file_id, 32'h33);
        check("tie2_len", m_len, 11'h020);
        handshake(1);
        repeat (2) @(negedge clk);
        m_done = 1'b1;
        wait_done(20, cnt);
        check("tie2_lat", cnt, 1);
        check("tie2_done", {b_done, b_err, a_done}, 3'b100);
        b_raddr = 9'h077;
        a_raddr = 9'h011;
        #1 check("tie2_raddr", m_raddr, 9'h077);
        @(negedge clk);
        b_release = 1'b1;
        @(negedge clk);
        b_release = 1'b0;
        check("tie2_rel", owner, 2'b00);
        a_valid = 1'b1; b_valid = 1'b1;
        #1 check("tie3", {a_ready, b_ready}, 2'b10);
        a_valid = 1'b0; b_valid = 1'b0;

        // Timeout with an early owner release that must be ignored.
        @(negedge clk);
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        check("tmo_m_valid", m_valid, 1'b1);
        handshake(0);
        @(negedge clk);
        a_release = 1'b1;
        @(negedge clk);
        a_release = 1'b0;
        check("tmo_wait_rel_ign", owner, 2'b01);
        wait_done(40, cnt);
        check("tmo_lat", cnt + 2, 16);
        check("tmo_done", {a_done, a_err, b_done, b_err}, 4'b1100);
        repeat (3) @(negedge clk);
        check("tmo_hold", owner, 2'b01);
        check("tmo_pulse", {a_done, a_err}, 2'b00);
        a_release = 1'b1;
        @(negedge clk);
        a_release = 1'b0;
        m_done = 1'b1;
        check("tmo_rel", owner, 2'b00);

        // Reset while in ISSUE.
        @(negedge clk);
        a_file_id = 32'h44;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        check("rsti_m_valid", m_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rsti_m_valid0", m_valid, 1'b0);
        check("rsti_owner0", owner, 2'b00);
        check("rsti_done0", {a_done, b_done, a_err, b_err}, 4'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_file_id = 32'h55;
        a_valid = 1'b1; b_valid = 1'b1;
        #1 check("rsti_tie", {a_ready, b_ready}, 2'b10);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        check("rsti_owner", owner, 2'b01);
        check("rsti_file", m_file_id, 32'h55);
        handshake(0);
        repeat (2) @(negedge clk);
        m_done = 1'b1;
        wait_done(20, cnt);
        check("rsti_lat", cnt, 1);
        check("rsti_done", {a_done, a_err}, 2'b10);
        @(negedge clk);
        a_release = 1'b1;
        @(negedge clk);
        a_release = 1'b0;
        check("rsti_rel", owner, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
